// File: rtl/ex_muldiv_pkg.sv
// Shared constants, state encoding and op-decode helpers for the RV32M multiply/divide unit.
package ex_muldiv_pkg;

    localparam int RegBus   = 32;
    localparam int AluOpBus = 8;

    localparam logic              RstEnable = 1'b1;
    localparam logic [RegBus-1:0] ZeroWord  = 32'h0000_0000;

    localparam logic [AluOpBus-1:0] EXE_MUL_OP    = 8'b0101_1000;
    localparam logic [AluOpBus-1:0] EXE_MULH_OP   = 8'b0101_1001;
    localparam logic [AluOpBus-1:0] EXE_MULHSU_OP = 8'b0101_1010;
    localparam logic [AluOpBus-1:0] EXE_MULHU_OP  = 8'b0101_1011;
    localparam logic [AluOpBus-1:0] EXE_DIV_OP    = 8'b0101_1100;
    localparam logic [AluOpBus-1:0] EXE_DIVU_OP   = 8'b0101_1101;
    localparam logic [AluOpBus-1:0] EXE_REM_OP    = 8'b0101_1110;
    localparam logic [AluOpBus-1:0] EXE_REMU_OP   = 8'b0101_1111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

    function automatic logic is_m_op(input logic [AluOpBus-1:0] op);
        return op inside {EXE_MUL_OP, EXE_MULH_OP, EXE_MULHSU_OP, EXE_MULHU_OP,
                          EXE_DIV_OP, EXE_DIVU_OP, EXE_REM_OP, EXE_REMU_OP};
    endfunction

    function automatic logic is_div_op(input logic [AluOpBus-1:0] op);
        return op inside {EXE_DIV_OP, EXE_DIVU_OP, EXE_REM_OP, EXE_REMU_OP};
    endfunction

    function automatic logic is_rem_op(input logic [AluOpBus-1:0] op);
        return op inside {EXE_REM_OP, EXE_REMU_OP};
    endfunction

    // MULHSU is the only op whose two operands differ in signedness.
    function automatic logic op1_signed(input logic [AluOpBus-1:0] op);
        return op inside {EXE_MUL_OP, EXE_MULH_OP, EXE_MULHSU_OP, EXE_DIV_OP, EXE_REM_OP};
    endfunction

    function automatic logic op2_signed(input logic [AluOpBus-1:0] op);
        return op inside {EXE_MUL_OP, EXE_MULH_OP, EXE_DIV_OP, EXE_REM_OP};
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative radix-2 restoring divider on unsigned magnitudes; 32 steps after start.
module muldiv_div_core
    import ex_muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [RegBus-1:0] dividend,
    input  logic [RegBus-1:0] divisor,
    output logic              done,
    output logic [RegBus-1:0] quotient,
    output logic [RegBus-1:0] remainder
);

    logic              busy;
    logic [4:0]        step;
    logic [RegBus-1:0] quo_q;
    logic [RegBus-1:0] rem_q;
    logic [RegBus-1:0] div_q;

    logic [RegBus:0]   partial;
    logic [RegBus+1:0] diff;
    logic [RegBus-1:0] quo_next;
    logic [RegBus-1:0] rem_next;

    // The dividend shifts out of quo_q's top while quotient bits shift in at the bottom.
    always_comb begin
        partial = {rem_q, quo_q[RegBus-1]};
        diff    = {1'b0, partial} - {2'b00, div_q};
        if (diff[RegBus+1]) begin
            rem_next = partial[RegBus-1:0];
            quo_next = {quo_q[RegBus-2:0], 1'b0};
        end else begin
            rem_next = diff[RegBus-1:0];
            quo_next = {quo_q[RegBus-2:0], 1'b1};
        end
    end

    // Results are presented during the final step so the caller can latch them on the same edge.
    assign done      = busy && (step == 5'd31) && !abort;
    assign quotient  = quo_next;
    assign remainder = rem_next;

    always_ff @(posedge clk) begin
        if (rst == RstEnable || abort) begin
            busy  <= 1'b0;
            step  <= 5'd0;
            quo_q <= ZeroWord;
            rem_q <= ZeroWord;
            div_q <= ZeroWord;
        end else if (start) begin
            busy  <= 1'b1;
            step  <= 5'd0;
            quo_q <= dividend;
            rem_q <= ZeroWord;
            div_q <= divisor;
        end else if (busy) begin
            quo_q <= quo_next;
            rem_q <= rem_next;
            step  <= step + 5'd1;
            if (step == 5'd31) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit for EX: stalls the pipeline until a one-cycle ready_o pulse.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier instead of the 32-cycle shift-add.
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                annul_i,
    input  logic [AluOpBus-1:0] aluop_i,
    input  logic [RegBus-1:0]   op1_i,
    input  logic [RegBus-1:0]   op2_i,
    output logic [RegBus-1:0]   result_o,
    output logic                ready_o,
    output logic                stallreq_o
);

    md_state_t           state;
    logic [5:0]          counter;
    logic [AluOpBus-1:0] aluop_q;
    logic                neg_q;
    logic                neg_r;

    logic                accept;
    logic                op_is_div;
    logic                op_is_rem;
    logic                sign1;
    logic                sign2;
    logic [RegBus-1:0]   mag1;
    logic [RegBus-1:0]   mag2;
    logic                div_zero;
    logic                div_ovf;

    logic                div_start;
    logic                div_done;
    logic [RegBus-1:0]   div_quo;
    logic [RegBus-1:0]   div_rem;
    logic [RegBus-1:0]   quo_fixed;
    logic [RegBus-1:0]   rem_fixed;

    assign accept    = start_i && !annul_i && is_m_op(aluop_i);
    assign op_is_div = is_div_op(aluop_i);
    assign op_is_rem = is_rem_op(aluop_i);
    assign sign1     = op1_signed(aluop_i) && op1_i[RegBus-1];
    assign sign2     = op2_signed(aluop_i) && op2_i[RegBus-1];
    assign mag1      = sign1 ? (ZeroWord - op1_i) : op1_i;
    assign mag2      = sign2 ? (ZeroWord - op2_i) : op2_i;
    assign div_zero  = (op2_i == ZeroWord);
    assign div_ovf   = op_is_div && op2_signed(aluop_i) &&
                       (op1_i == 32'h8000_0000) && (op2_i == 32'hFFFF_FFFF);

    assign div_start = (state == MD_IDLE) && accept && op_is_div && !div_zero && !div_ovf;

    muldiv_div_core u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (annul_i),
        .dividend  (mag1),
        .divisor   (mag2),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Quotient sign follows the operand signs; remainder follows the dividend.
    assign quo_fixed = neg_q ? (ZeroWord - div_quo) : div_quo;
    assign rem_fixed = neg_r ? (ZeroWord - div_rem) : div_rem;

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] wide1;
    logic [63:0] wide2;
    logic [63:0] fast_product;

    // Sign-extending to 64 bits gives the signed 33x33 product in the low 64 bits.
    assign wide1        = {{32{sign1}}, op1_i};
    assign wide2        = {{32{sign2}}, op2_i};
    assign fast_product = wide1 * wide2;
`else
    logic [63:0]       acc;
    logic [63:0]       mcand;
    logic [RegBus-1:0] mplier;
    logic [63:0]       acc_next;
    logic [63:0]       product;

    assign acc_next = acc + (mplier[0] ? mcand : 64'd0);
    assign product  = neg_q ? (64'd0 - acc_next) : acc_next;
`endif

    assign stallreq_o = (rst != RstEnable) && !annul_i &&
                        (((state == MD_IDLE) && accept) || (state == MD_MUL) || (state == MD_DIV));

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state    <= MD_IDLE;
            counter  <= 6'd0;
            aluop_q  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= ZeroWord;
            ready_o  <= 1'b0;
        end else if (annul_i) begin
            state   <= MD_IDLE;
            counter <= 6'd0;
            ready_o <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (accept) begin
                        aluop_q <= aluop_i;
                        counter <= 6'd0;
                        neg_q   <= sign1 ^ sign2;
                        neg_r   <= sign1;
                        if (op_is_div) begin
                            if (div_zero) begin
                                result_o <= op_is_rem ? op1_i : 32'hFFFF_FFFF;
                                ready_o  <= 1'b1;
                                state    <= MD_DONE;
                            end else if (div_ovf) begin
                                result_o <= op_is_rem ? ZeroWord : 32'h8000_0000;
                                ready_o  <= 1'b1;
                                state    <= MD_DONE;
                            end else begin
                                state <= MD_DIV;
                            end
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            result_o <= (aluop_i == EXE_MUL_OP) ? fast_product[31:0] : fast_product[63:32];
                            ready_o  <= 1'b1;
                            state    <= MD_DONE;
`else
                            acc    <= 64'd0;
                            mcand  <= {32'd0, mag1};
                            mplier <= mag2;
                            state  <= MD_MUL;
`endif
                        end
                    end
                end
                MD_DIV: begin
                    counter <= counter + 6'd1;
                    if (div_done) begin
                        result_o <= is_rem_op(aluop_q) ? rem_fixed : quo_fixed;
                        ready_o  <= 1'b1;
                        state    <= MD_DONE;
                    end
                end
`ifdef MULDIV_FAST_MUL_EN
`else
                MD_MUL: begin
                    acc     <= acc_next;
                    mcand   <= {mcand[62:0], 1'b0};
                    mplier  <= {1'b0, mplier[RegBus-1:1]};
                    counter <= counter + 6'd1;
                    if (counter == 6'd31) begin
                        result_o <= (aluop_q == EXE_MUL_OP) ? product[31:0] : product[63:32];
                        ready_o  <= 1'b1;
                        state    <= MD_DONE;
                    end
                end
`endif
                MD_DONE: begin
                    state <= MD_IDLE;
                end
                default: begin
                    state <= MD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M corner cases plus randomized ops vs. an arithmetic model.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MulLatency = 1;
`else
    localparam int MulLatency = 33;
`endif

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expected;
        int          latency;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic [7:0]  aluop_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    ex_muldiv dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .aluop_i    (aluop_i),
        .op1_i      (op1_i),
        .op2_i      (op2_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    // Reference result straight from the RV32M arithmetic definitions.
    function automatic logic [31:0] ref_result(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        int              ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            EXE_MUL_OP:    begin up = ua * ub; return up[31:0]; end
            EXE_MULH_OP:   begin sp = sa * sb; return sp[63:32]; end
            EXE_MULHSU_OP: begin sp = sa * longint'(ub); return sp[63:32]; end
            EXE_MULHU_OP:  begin up = ua * ub; return up[63:32]; end
            EXE_DIV_OP: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            EXE_REM_OP: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            EXE_DIVU_OP: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            EXE_REMU_OP: return (b == 32'd0) ? a : a % b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic int ref_latency(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op inside {EXE_DIV_OP, EXE_DIVU_OP, EXE_REM_OP, EXE_REMU_OP}) begin
            if (b == 32'd0) return 1;
            if ((op inside {EXE_DIV_OP, EXE_REM_OP}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
        return MulLatency;
    endfunction

    // Called at posedge+1 of cycle N; returns at posedge+1 of the ready cycle with start dropped.
    task automatic applyStimulus(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output int lat, output bit stall_ok);
        start_i  = 1'b1;
        aluop_i  = op;
        op1_i    = a;
        op2_i    = b;
        res      = 32'd0;
        lat      = -1;
        stall_ok = 1'b1;
        #1;
        if (stallreq_o !== 1'b1) stall_ok = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (ready_o === 1'b1) begin
                lat = k;
                res = result_o;
                if (stallreq_o !== 1'b0) stall_ok = 1'b0;
                break;
            end
            if (stallreq_o !== 1'b1) stall_ok = 1'b0;
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        annul_i = 1'b0;
        start_i = 1'b1;
        aluop_i = EXE_DIVU_OP;
        op1_i   = 32'd100;
        op2_i   = 32'd7;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (result_o !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_result: got %h expected 00000000", result_o); end
        compared++;
        if (ready_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ready: got %b expected 0", ready_o); end
        compared++;
        if (stallreq_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_stall: got %b expected 0", stallreq_o); end
        rst     = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        compared++;
        if (ready_o !== 1'b0 || stallreq_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL post_reset_idle: got ready=%b stall=%b expected 0/0", ready_o, stallreq_o);
        end
    endtask

    task automatic test_directed();
        vec_t        tbl[$];
        logic [31:0] res;
        int          lat;
        bit          stall_ok;
        tbl.push_back('{EXE_DIVU_OP,   32'd100,       32'd7,         32'd14,        33,         "divu_100_7"});
        tbl.push_back('{EXE_REMU_OP,   32'd100,       32'd7,         32'd2,         33,         "remu_100_7"});
        tbl.push_back('{EXE_DIV_OP,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,          "div_overflow"});
        tbl.push_back('{EXE_REM_OP,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,          "rem_overflow"});
        tbl.push_back('{EXE_DIV_OP,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33,         "div_m7_2"});
        tbl.push_back('{EXE_REM_OP,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33,         "rem_m7_2"});
        tbl.push_back('{EXE_DIVU_OP,   32'd5,         32'd0,         32'hFFFF_FFFF, 1,          "divu_by_zero"});
        tbl.push_back('{EXE_REM_OP,    32'd5,         32'd0,         32'd5,         1,          "rem_by_zero"});
        tbl.push_back('{EXE_MUL_OP,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MulLatency, "mul_ones"});
        tbl.push_back('{EXE_MULH_OP,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MulLatency, "mulh_ones"});
        tbl.push_back('{EXE_MULHU_OP,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MulLatency, "mulhu_ones"});
        tbl.push_back('{EXE_MULHSU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MulLatency, "mulhsu_ones"});
        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            applyStimulus(tbl[i].op, tbl[i].a, tbl[i].b, res, lat, stall_ok);
            compared++;
            if (res !== tbl[i].expected) begin
                mismatched++;
                $display("[TB] FAIL %s result: got %h expected %h", tbl[i].name, res, tbl[i].expected);
            end
            compared++;
            if (lat != tbl[i].latency) begin
                mismatched++;
                $display("[TB] FAIL %s latency: got %0d expected %0d", tbl[i].name, lat, tbl[i].latency);
            end
            compared++;
            if (stall_ok !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL %s stall_profile: got %b expected 1", tbl[i].name, stall_ok);
            end
        end
    endtask

    task automatic test_invalid_op();
        bit bad;
        bad = 1'b0;
        @(posedge clk);
        #1;
        start_i = 1'b1;
        aluop_i = 8'h00;
        op1_i   = 32'd12;
        op2_i   = 32'd4;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (stallreq_o !== 1'b0 || ready_o !== 1'b0) bad = 1'b1;
            @(posedge clk);
            #1;
        end
        start_i = 1'b0;
        compared++;
        if (bad !== 1'b0) begin mismatched++; $display("[TB] FAIL non_m_op_ignored: got activity=%b expected 0", bad); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res1, res2, a1, b1, a2, b2, exp1, exp2;
        int          lat1, lat2;
        bit          ok1, ok2;
        a1 = $urandom; b1 = $urandom;
        a2 = $urandom; b2 = $urandom_range(1, 1000);
        exp1 = ref_result(EXE_MULHU_OP, a1, b1);
        exp2 = ref_result(EXE_DIVU_OP, a2, b2);
        @(posedge clk);
        #1;
        applyStimulus(EXE_MULHU_OP, a1, b1, res1, lat1, ok1);
        @(posedge clk);
        #1;
        compared++;
        if (ready_o !== 1'b0) begin mismatched++; $display("[TB] FAIL ready_single_pulse: got %b expected 0", ready_o); end
        compared++;
        if (result_o !== exp1) begin mismatched++; $display("[TB] FAIL result_hold: got %h expected %h", result_o, exp1); end
        applyStimulus(EXE_DIVU_OP, a2, b2, res2, lat2, ok2);
        compared++;
        if (res1 !== exp1 || lat1 != MulLatency) begin
            mismatched++;
            $display("[TB] FAIL b2b_first: got %h lat %0d expected %h lat %0d", res1, lat1, exp1, MulLatency);
        end
        compared++;
        if (res2 !== exp2 || lat2 != 33 || ok2 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL b2b_second: got %h lat %0d stall %b expected %h lat 33 stall 1", res2, lat2, ok2, exp2);
        end
    endtask

    task automatic test_annul();
        logic [31:0] res;
        int          lat;
        bit          stall_ok, bad;
        bad = 1'b0;
        @(posedge clk);
        #1;
        start_i = 1'b1;
        aluop_i = EXE_DIV_OP;
        op1_i   = 32'hFFFF_FC18;
        op2_i   = 32'd3;
        for (int k = 1; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (ready_o !== 1'b0 || stallreq_o !== 1'b1) bad = 1'b1;
        end
        @(posedge clk);
        #1;
        annul_i = 1'b1;
        #1;
        compared++;
        if (bad !== 1'b0) begin mismatched++; $display("[TB] FAIL div_stall_before_annul: got error=%b expected 0", bad); end
        compared++;
        if (stallreq_o !== 1'b0) begin mismatched++; $display("[TB] FAIL annul_stall: got %b expected 0", stallreq_o); end
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        compared++;
        if (ready_o !== 1'b0) begin mismatched++; $display("[TB] FAIL annul_no_ready: got %b expected 0", ready_o); end
        applyStimulus(EXE_DIVU_OP, 32'd9, 32'd3, res, lat, stall_ok);
        compared++;
        if (res !== 32'd3) begin mismatched++; $display("[TB] FAIL after_annul_result: got %h expected 00000003", res); end
        compared++;
        if (lat != 33) begin mismatched++; $display("[TB] FAIL after_annul_latency: got %0d expected 33", lat); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int          lat;
        bit          stall_ok, bad;
        bad = 1'b0;
        @(posedge clk);
        #1;
        start_i = 1'b1;
        aluop_i = EXE_DIVU_OP;
        op1_i   = 32'h0000_FFFF;
        op2_i   = 32'd3;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        compared++;
        if (result_o !== 32'd0) begin mismatched++; $display("[TB] FAIL midreset_result: got %h expected 00000000", result_o); end
        compared++;
        if (ready_o !== 1'b0 || stallreq_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midreset_ctrl: got ready=%b stall=%b expected 0/0", ready_o, stallreq_o);
        end
        rst     = 1'b0;
        start_i = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (ready_o !== 1'b0) bad = 1'b1;
        end
        compared++;
        if (bad !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_aborted: got ready seen=%b expected 0", bad); end
        applyStimulus(EXE_REMU_OP, 32'd100, 32'd7, res, lat, stall_ok);
        compared++;
        if (res !== 32'd2 || lat != 33) begin
            mismatched++;
            $display("[TB] FAIL after_reset_op: got %h lat %0d expected 00000002 lat 33", res, lat);
        end
    endtask

    task automatic test_random();
        logic [7:0]  ops[8];
        logic [7:0]  op;
        logic [31:0] a, b, res, exp;
        int          lat, exp_lat;
        bit          stall_ok;
        ops = '{EXE_MUL_OP, EXE_MULH_OP, EXE_MULHSU_OP, EXE_MULHU_OP,
                EXE_DIV_OP, EXE_DIVU_OP, EXE_REM_OP, EXE_REMU_OP};
        for (int i = 0; i < 48; i++) begin
            op = ops[$urandom_range(0, 7)];
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 200) - 100; b = $urandom_range(0, 20) - 10; end
                default: ;
            endcase
            exp     = ref_result(op, a, b);
            exp_lat = ref_latency(op, a, b);
            @(posedge clk);
            #1;
            applyStimulus(op, a, b, res, lat, stall_ok);
            compared++;
            if (res !== exp) begin
                mismatched++;
                $display("[TB] FAIL random_%0d op %h a %h b %h: got %h expected %h", i, op, a, b, res, exp);
            end
            compared++;
            if (lat != exp_lat || stall_ok !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL random_%0d_timing op %h: got lat %0d stall %b expected lat %0d stall 1",
                         i, op, lat, stall_ok, exp_lat);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        start_i = 1'b0;
        annul_i = 1'b0;
        aluop_i = 8'h00;
        op1_i   = 32'd0;
        op2_i   = 32'd0;
        test_reset();
        test_directed();
        test_invalid_op();
        test_back_to_back();
        test_annul();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, got no completion expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
